// File: rtl/dff_bist.sv
// Purpose: built-in self-test engine for one posedge D flip-flop with async active-low reset.
// Latency: done rises NUM_VECTORS+7 edges after the start-accept edge (23 with the defaults).
// Backpressure: none; start is a 1-cycle request and is ignored while busy=1.
//
// Edge schedule of one run (edge 0 = start accepted, N = NUM_VECTORS):
//   1..N    DATA  launch LFSR bit, expect it back on Q two edges later
//   N+1     DRAIN launch 0, no expectation (last data bits still in the pipe)
//   N+2,N+3 PRE   launch 1, expect Q=1 at N+4 and N+5
//   N+4     ARM   keep D=1, expect Q=0 at N+6 (reset is asserted at N+5)
//   N+5,N+6 RST   RUT reset low, D=1; N+5 expects Q=0 at N+7
//   N+7     REL   release RUT reset, last reset check lands, done/pass latched
// The reset checks keep D=1 so a flop that ignores its reset reads back 1.
module dff_bist #(
    parameter int         NUM_VECTORS = 16,
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter int         CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             nReset,
    input  logic             start,
    output logic             dut_d,
    output logic             dut_nreset,
    input  logic             dut_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam int PH_W = $clog2(NUM_VECTORS) + 1;
    localparam logic [PH_W-1:0] DATA_LAST = PH_W'(NUM_VECTORS - 1);
    localparam logic [PH_W-1:0] PH_ONE    = PH_W'(1);
    localparam logic [PH_W-1:0] PH_ZERO   = '0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        DRAIN = 3'd2,
        PRE   = 3'd3,
        ARM   = 3'd4,
        RST   = 3'd5,
        REL   = 3'd6,
        DONE  = 3'd7
    } state_t;

    state_t           state_q;
    logic [PH_W-1:0]  cnt_q;
    logic [7:0]       lfsr_q;
    logic [7:0]       lfsr_d;
    logic             exp1_q;
    logic             exp2_q;
    logic             v1_q;
    logic             v2_q;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] err_d;
    logic             dut_d_q;
    logic             dut_nreset_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    // Next LFSR state and the saturating error count after this edge's check.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        err_d  = err_q;
        if (v2_q && (dut_q != exp2_q) && (err_q != {CNT_W{1'b1}})) begin
            err_d = err_q + CNT_W'(1);
        end
    end

    // Test sequencer: phase FSM, expect pipe, error counter and registered RUT drives.
    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lfsr_q       <= SEED;
            exp1_q       <= 1'b0;
            exp2_q       <= 1'b0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            err_q        <= '0;
            dut_d_q      <= 1'b0;
            dut_nreset_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            // Pipe advances every cycle; the stage-2 check lands via err_d.
            exp2_q <= exp1_q;
            v2_q   <= v1_q;
            err_q  <= err_d;
            case (state_q)
                IDLE, DONE: begin
                    dut_nreset_q <= 1'b1;
                    v1_q         <= 1'b0;
                    if (start) begin
                        state_q <= DATA;
                        cnt_q   <= DATA_LAST;
                        lfsr_q  <= SEED;
                        exp1_q  <= 1'b0;
                        exp2_q  <= 1'b0;
                        v2_q    <= 1'b0;
                        err_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                DATA: begin
                    dut_d_q <= lfsr_q[7];
                    exp1_q  <= lfsr_q[7];
                    v1_q    <= 1'b1;
                    lfsr_q  <= lfsr_d;
                    if (cnt_q == PH_ZERO) begin
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q - PH_ONE;
                    end
                end
                DRAIN: begin
                    dut_d_q <= 1'b0;
                    exp1_q  <= 1'b0;
                    v1_q    <= 1'b0;
                    cnt_q   <= PH_ONE;
                    state_q <= PRE;
                end
                PRE: begin
                    dut_d_q <= 1'b1;
                    exp1_q  <= 1'b1;
                    v1_q    <= 1'b1;
                    if (cnt_q == PH_ZERO) begin
                        state_q <= ARM;
                    end else begin
                        cnt_q <= cnt_q - PH_ONE;
                    end
                end
                ARM: begin
                    dut_d_q <= 1'b1;
                    exp1_q  <= 1'b0;
                    v1_q    <= 1'b1;
                    cnt_q   <= PH_ONE;
                    state_q <= RST;
                end
                RST: begin
                    dut_nreset_q <= 1'b0;
                    dut_d_q      <= 1'b1;
                    exp1_q       <= 1'b0;
                    // Only the first reset edge queues a check; the second lands at REL.
                    v1_q         <= (cnt_q == PH_ONE);
                    if (cnt_q == PH_ZERO) begin
                        state_q <= REL;
                    end else begin
                        cnt_q <= cnt_q - PH_ONE;
                    end
                end
                REL: begin
                    dut_nreset_q <= 1'b1;
                    dut_d_q      <= 1'b0;
                    exp1_q       <= 1'b0;
                    v1_q         <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                    pass_q       <= (err_d == '0);
                    state_q      <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dut_d      = dut_d_q;
    assign dut_nreset = dut_nreset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;

endmodule
